// File: rtl/avfs_clk_stepper.sv
// avfs_clk_stepper: turns the AVFS freq_sel code into a divided clock enable.
// Code changes are slew-limited: one code per step, taken only on a divider
// period boundary, then held for a settle dwell before the next step.
module avfs_clk_stepper #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       freq_sel,
    output logic             clk_en,
    output logic [3:0]       freq_cur,
    output logic             busy,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STEADY     = 2'd0,
        WAIT_BOUND = 2'd1,
        SETTLE     = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       tgt_q;
    logic [3:0]       freq_cur_q;
    logic [3:0]       div_cnt_q;
    logic [3:0]       div_cnt_d;
    logic             clk_en_q;
    logic             clk_en_d;
    logic             step_pulse_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic [4:0]       ratio;
    logic             boundary;

    // Step counter saturates at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // One code toward the target; caller guarantees tgt != cur, so no wrap.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        return (tgt > cur) ? cur + 4'd1 : cur - 4'd1;
    endfunction

    // Divider ratio from the applied code (F -> 1 ... 0 -> 16) and period boundary detect.
    always_comb begin
        ratio     = 5'd16 - {1'b0, freq_cur_q};
        boundary  = ({1'b0, div_cnt_q} == (ratio - 5'd1));
        div_cnt_d = boundary ? 4'd0 : div_cnt_q + 4'd1;
        clk_en_d  = boundary;
    end

    // Divider counter and registered enable pulse; the boundary pulse is always issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= 4'd0;
            clk_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_en_q  <= clk_en_d;
        end
    end

    // Slew-limiting FSM: detect target change, step on a boundary, then dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STEADY;
            tgt_q        <= 4'hF;
            freq_cur_q   <= 4'hF;
            step_pulse_q <= 1'b0;
            step_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            tgt_q        <= freq_sel;
            step_pulse_q <= 1'b0;
            case (state_q)
                STEADY: begin
                    if (tgt_q != freq_cur_q) begin
                        state_q <= WAIT_BOUND;
                    end
                end
                WAIT_BOUND: begin
                    if (boundary) begin
                        if (tgt_q == freq_cur_q) begin
                            // Target came back before a step was taken: absorb the glitch.
                            state_q <= STEADY;
                        end else begin
                            // New ratio governs the period that begins at this same edge.
                            freq_cur_q   <= step_toward(freq_cur_q, tgt_q);
                            step_pulse_q <= 1'b1;
                            step_cnt_q   <= sat_inc(step_cnt_q);
                            settle_cnt_q <= SETTLE_LOAD;
                            state_q      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= (tgt_q == freq_cur_q) ? STEADY : WAIT_BOUND;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SET_W'(1);
                    end
                end
                default: begin
                    state_q <= STEADY;
                end
            endcase
        end
    end

    assign clk_en     = clk_en_q;
    assign freq_cur   = freq_cur_q;
    assign busy       = (state_q != STEADY);
    assign step_pulse = step_pulse_q;
    assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_avfs_clk_stepper.sv
// Directed bench for avfs_clk_stepper: reset, ramps, reversal, slowest code,
// reset mid-ramp and a one-cycle target glitch, plus a cycle monitor that
// checks step placement, spacing and every clk_en period.
module tb_avfs_clk_stepper;

    localparam int SETTLE = 16;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    freq_sel = 4'hF;
    logic          clk_en;
    logic [3:0]    freq_cur;
    logic          busy;
    logic          step_pulse;
    logic [CW-1:0] step_cnt;

    int n_checks = 0;
    int n_errors = 0;

    avfs_clk_stepper #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_sel   (freq_sel),
        .clk_en     (clk_en),
        .freq_cur   (freq_cur),
        .busy       (busy),
        .step_pulse (step_pulse),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- cycle monitor ----------------
    logic       rst_edge = 1'b1;
    logic [3:0] prev_fc  = 4'hF;
    int         cyc = 0;
    int         last_pulse = 0;
    int         exp_ratio = 1;
    bit         have_pulse = 0;
    int         last_step = 0;
    bit         have_step = 0;
    logic [3:0] steps[$];

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        int d;
        cyc++;
        if (rst_edge) begin
            have_pulse = 0;
            have_step  = 0;
        end else begin
            check_val("step_vs_change", int'(step_pulse), int'(freq_cur != prev_fc));
            if (step_pulse) begin
                d = int'(freq_cur) - int'(prev_fc);
                check_val("step_on_boundary", int'(clk_en), 1);
                check_val("step_size_one", int'(d == 1 || d == -1), 1);
                if (have_step) check_val("step_gap_ge_17", int'((cyc - last_step) >= SETTLE + 1), 1);
                last_step = cyc;
                have_step = 1;
                steps.push_back(freq_cur);
            end
            if (clk_en) begin
                if (have_pulse) check_val("clk_en_period", cyc - last_pulse, exp_ratio);
                last_pulse = cyc;
                exp_ratio  = 16 - int'(freq_cur);
                have_pulse = 1;
            end
        end
        prev_fc = freq_cur;
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        freq_sel = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        steps.delete();
    endtask

    task automatic wait_code(input logic [3:0] code, input bit need_idle, input int maxc);
        int n;
        n = 0;
        while (!((freq_cur == code) && (!need_idle || !busy)) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) check_val("wait_timeout", int'(freq_cur), int'(code));
    endtask

    task automatic measure_period(output int p);
        int n;
        n = 0;
        @(negedge clk);
        while (clk_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        p = 0;
        do begin
            @(negedge clk);
            p++;
        end while (clk_en !== 1'b1 && p < 40);
    endtask

    task automatic check_steps(input string tag, input logic [3:0] exp_s[$]);
        check_val({tag, "_count"}, steps.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < steps.size(); i++)
            check_val({tag, "_code"}, int'(steps[i]), int'(exp_s[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int p;
        int busy_seen;
        int pulses;
        logic [3:0] exp_s[$];

        // 1: reset held three cycles, then ratio 1 gives clk_en every cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_clk_en", int'(clk_en), 0);
            check_val("rst_freq_cur", int'(freq_cur), 15);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("post_rst_clk_en", int'(clk_en), 1);
            check_val("post_rst_busy", int'(busy), 0);
        end
        check_val("post_rst_step_cnt", int'(step_cnt), 0);
        check_val("post_rst_step_pulse", int'(step_pulse), 0);

        // 2: ramp F -> A; busy rises on the 2nd edge after the change
        steps.delete();
        freq_sel = 4'hA;
        @(negedge clk);
        check_val("busy_after_1_edge", int'(busy), 0);
        @(negedge clk);
        check_val("busy_after_2_edges", int'(busy), 1);
        wait_code(4'hA, 1'b1, 600);
        check_val("ramp_down_code", int'(freq_cur), 10);
        check_val("ramp_down_busy", int'(busy), 0);
        check_val("ramp_down_step_cnt", int'(step_cnt), 5);
        exp_s = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
        check_steps("ramp_down", exp_s);
        measure_period(p);
        check_val("period_code_A", p, 6);

        // 3: reversal at C back to F
        do_reset();
        freq_sel = 4'hA;
        wait_code(4'hC, 1'b0, 600);
        freq_sel = 4'hF;
        wait_code(4'hF, 1'b1, 600);
        check_val("reversal_code", int'(freq_cur), 15);
        check_val("reversal_step_cnt", int'(step_cnt), 6);
        exp_s = '{4'hE, 4'hD, 4'hC, 4'hD, 4'hE, 4'hF};
        check_steps("reversal", exp_s);

        // 4: slowest code, fifteen more steps
        freq_sel = 4'h0;
        wait_code(4'h0, 1'b1, 2000);
        check_val("slowest_code", int'(freq_cur), 0);
        check_val("slowest_step_cnt", int'(step_cnt), 21);
        measure_period(p);
        check_val("period_code_0", p, 16);

        // 6: one-cycle glitch of the target at code 0
        @(negedge clk);
        freq_sel = 4'h1;
        @(negedge clk);
        freq_sel = 4'h0;
        busy_seen = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
            if (step_pulse) pulses++;
        end
        check_val("glitch_busy_pulsed", busy_seen, 1);
        check_val("glitch_no_step", pulses, 0);
        check_val("glitch_code", int'(freq_cur), 0);
        check_val("glitch_busy_end", int'(busy), 0);
        check_val("glitch_step_cnt", int'(step_cnt), 21);

        // 5: reset asserted mid-ramp at code C
        do_reset();
        freq_sel = 4'hA;
        wait_code(4'hC, 1'b0, 600);
        rst = 1'b1;
        freq_sel = 4'hF;
        @(negedge clk);
        check_val("midramp_rst_code", int'(freq_cur), 15);
        check_val("midramp_rst_busy", int'(busy), 0);
        check_val("midramp_rst_step_cnt", int'(step_cnt), 0);
        check_val("midramp_rst_clk_en", int'(clk_en), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("after_midramp_clk_en", int'(clk_en), 1);
        check_val("after_midramp_busy", int'(busy), 0);
        check_val("after_midramp_code", int'(freq_cur), 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
